// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU opcodes and payload types for the ID/EX pipeline register.
// Optional feature macro: ID_EX_FORWARD_EN (MEM/WB operand forwarding).
package id_ex_stage_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REG_ADDR_WIDTH = 5;
  localparam int unsigned ALU_OP_WIDTH   = 4;

  typedef logic [DATA_WIDTH-1:0]     data_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [ALU_OP_WIDTH-1:0]   alu_op_t;

  localparam alu_op_t ALU_ADD   = 4'd0;
  localparam alu_op_t ALU_SUB   = 4'd1;
  localparam alu_op_t ALU_AND   = 4'd2;
  localparam alu_op_t ALU_OR    = 4'd3;
  localparam alu_op_t ALU_XOR   = 4'd4;
  localparam alu_op_t ALU_SLT   = 4'd5;
  localparam alu_op_t ALU_SLL   = 4'd6;
  localparam alu_op_t ALU_SRL   = 4'd7;
  localparam alu_op_t ALU_PASS2 = 4'd8;

  localparam reg_addr_t ZERO_REG = '0;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

  // Everything latched by the stage on one edge.
  typedef struct packed {
    logic      valid;
    alu_op_t   alu_op;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
    logic      alu_src;
    ctrl_t     ctrl;
    data_t     data1;
    data_t     data2;
    data_t     imm;
  } ex_reg_t;

  // A writer matches a source if it writes, targets it, and it is not r0.
  function automatic logic fwd_hit(input logic wr, input reg_addr_t rd, input reg_addr_t src);
    return wr && (rd == src) && (src != ZERO_REG);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, forwarding and execute-side buses around the ID/EX register.
interface id_ex_stage_if;
  import id_ex_stage_pkg::*;

  logic      stall;
  logic      flush;
  logic      id_valid;
  alu_op_t   id_alu_op;
  reg_addr_t id_rs;
  reg_addr_t id_rt;
  reg_addr_t id_rd;
  data_t     id_reg_data1;
  data_t     id_reg_data2;
  data_t     id_imm;
  logic      id_alu_src;
  logic      id_reg_write;
  logic      id_mem_read;
  logic      id_mem_write;

  logic      mem_reg_write;
  reg_addr_t mem_rd;
  data_t     mem_result;
  logic      wb_reg_write;
  reg_addr_t wb_rd;
  data_t     wb_result;

  logic      ex_valid;
  alu_op_t   ex_alu_op;
  data_t     ex_data1;
  data_t     ex_data2;
  data_t     ex_store_data;
  reg_addr_t ex_rd;
  logic      ex_reg_write;
  logic      ex_mem_read;
  logic      ex_mem_write;
  logic      load_use_stall;

  modport master (
    output stall, flush, id_valid, id_alu_op, id_rs, id_rt, id_rd,
           id_reg_data1, id_reg_data2, id_imm, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    input  ex_valid, ex_alu_op, ex_data1, ex_data2, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_alu_op, id_rs, id_rt, id_rd,
           id_reg_data1, id_reg_data2, id_imm, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write,
           mem_reg_write, mem_rd, mem_result, wb_reg_write, wb_rd, wb_result,
    output ex_valid, ex_alu_op, ex_data1, ex_data2, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Resolves one source operand against the MEM and WB write-back buses.
module fwd_mux
  import id_ex_stage_pkg::*;
(
  input  reg_addr_t src,
  input  data_t     reg_val,
  input  logic      mem_reg_write,
  input  reg_addr_t mem_rd,
  input  data_t     mem_result,
  input  logic      wb_reg_write,
  input  reg_addr_t wb_rd,
  input  data_t     wb_result,
  output data_t     fwd_val_c
);

  // Youngest writer (MEM) has priority over WB; r0 never forwards.
  always_comb begin
    fwd_val_c = reg_val;
    if (fwd_hit(mem_reg_write, mem_rd, src)) begin
      fwd_val_c = mem_result;
    end else if (fwd_hit(wb_reg_write, wb_rd, src)) begin
      fwd_val_c = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decode fields, forwards operands, and
// raises load_use_stall / inserts bubbles on RAW hazards.
// Optional feature macro: ID_EX_FORWARD_EN. Without it the operands are the
// latched values and any RAW hazard against EX/MEM/WB bubbles instead.
module id_ex_stage
  import id_ex_stage_pkg::*;
(
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);

  ex_reg_t cur_q;
  ex_reg_t nxt;
  data_t   rs_val_c;
  data_t   rt_val_c;
  logic    hazard_c;
  logic    load_use_c;

  // True when a nonzero destination matches either decode source (rt always).
  function automatic logic src_match(input reg_addr_t rd, input reg_addr_t rs, input reg_addr_t rt);
    return (rd != ZERO_REG) && ((rd == rs) || (rd == rt));
  endfunction

`ifdef ID_EX_FORWARD_EN
  fwd_mux u_fwd_rs (
    .src           (cur_q.rs),
    .reg_val       (cur_q.data1),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_result    (bus.mem_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_result     (bus.wb_result),
    .fwd_val_c     (rs_val_c)
  );

  fwd_mux u_fwd_rt (
    .src           (cur_q.rt),
    .reg_val       (cur_q.data2),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd        (bus.mem_rd),
    .mem_result    (bus.mem_result),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd         (bus.wb_rd),
    .wb_result     (bus.wb_result),
    .fwd_val_c     (rt_val_c)
  );

  // Only a load in EX cannot be forwarded in time.
  always_comb begin
    hazard_c = bus.id_valid && cur_q.valid && cur_q.ctrl.mem_read &&
               src_match(cur_q.rd, bus.id_rs, bus.id_rt);
  end
`else
  logic unused_fwd_data;

  assign rs_val_c        = cur_q.data1;
  assign rt_val_c        = cur_q.data2;
  assign unused_fwd_data = ^{bus.mem_result, bus.wb_result};

  // No bypass network: any in-flight writer of a source must drain first.
  always_comb begin
    hazard_c = bus.id_valid &&
               ((cur_q.valid && cur_q.ctrl.reg_write && src_match(cur_q.rd, bus.id_rs, bus.id_rt)) ||
                (bus.mem_reg_write && src_match(bus.mem_rd, bus.id_rs, bus.id_rt)) ||
                (bus.wb_reg_write && src_match(bus.wb_rd, bus.id_rs, bus.id_rt)));
  end
`endif

  assign load_use_c = hazard_c && !bus.stall;

  // Next-state: flush > stall > hazard bubble > normal capture.
  always_comb begin
    nxt = cur_q;
    if (bus.flush) begin
      nxt = '0;
    end else if (bus.stall) begin
      // Hold, but refresh operands so a write-back during the stall sticks.
      nxt.data1 = rs_val_c;
      nxt.data2 = rt_val_c;
    end else if (load_use_c) begin
      nxt = '0;
    end else begin
      nxt.valid          = bus.id_valid;
      nxt.alu_op         = bus.id_alu_op;
      nxt.rs             = bus.id_rs;
      nxt.rt             = bus.id_rt;
      nxt.rd             = bus.id_rd;
      nxt.alu_src        = bus.id_alu_src;
      nxt.ctrl.reg_write = bus.id_reg_write && bus.id_valid;
      nxt.ctrl.mem_read  = bus.id_mem_read  && bus.id_valid;
      nxt.ctrl.mem_write = bus.id_mem_write && bus.id_valid;
      nxt.data1          = bus.id_reg_data1;
      nxt.data2          = bus.id_reg_data2;
      nxt.imm            = bus.id_imm;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= '0;
    end else begin
      cur_q <= nxt;
    end
  end

  assign bus.ex_valid       = cur_q.valid;
  assign bus.ex_alu_op      = cur_q.alu_op;
  assign bus.ex_data1       = rs_val_c;
  assign bus.ex_data2       = cur_q.alu_src ? cur_q.imm : rt_val_c;
  assign bus.ex_store_data  = rt_val_c;
  assign bus.ex_rd          = cur_q.rd;
  assign bus.ex_reg_write   = cur_q.ctrl.reg_write;
  assign bus.ex_mem_read    = cur_q.ctrl.mem_read;
  assign bus.ex_mem_write   = cur_q.ctrl.mem_write;
  assign bus.load_use_stall = load_use_c;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct {
    logic        reset, stall, flush, id_valid;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] d1, d2, imm;
    logic        alu_src, rw, mr, mw;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic        w_rw;
    logic [4:0]  w_rd;
    logic [31:0] w_res;
    logic        chk_lus, e_lus;
    logic        chk_data;
    logic        e_valid, e_rw, e_mr, e_mw;
    logic [3:0]  e_op;
    logic [4:0]  e_rd;
    logic [31:0] e_d1, e_d2, e_sd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    v.chk_lus  = 1'b1;
    v.chk_data = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset             = v.reset;
    bus.stall         = v.stall;
    bus.flush         = v.flush;
    bus.id_valid      = v.id_valid;
    bus.id_alu_op     = v.op;
    bus.id_rs         = v.rs;
    bus.id_rt         = v.rt;
    bus.id_rd         = v.rd;
    bus.id_reg_data1  = v.d1;
    bus.id_reg_data2  = v.d2;
    bus.id_imm        = v.imm;
    bus.id_alu_src    = v.alu_src;
    bus.id_reg_write  = v.rw;
    bus.id_mem_read   = v.mr;
    bus.id_mem_write  = v.mw;
    bus.mem_reg_write = v.m_rw;
    bus.mem_rd        = v.m_rd;
    bus.mem_result    = v.m_res;
    bus.wb_reg_write  = v.w_rw;
    bus.wb_rd         = v.w_rd;
    bus.wb_result     = v.w_res;
  endtask

  initial begin
    vec_t v;
    drive(blank());
    reset = 1'b1;

    // 0,1: reset for two cycles
    v = blank(); v.reset = 1; v.chk_lus = 0; tbl.push_back(v);
    v = blank(); v.reset = 1; tbl.push_back(v);
    // 2: ADD r3 = r1 + r2 (5, 7)
    v = blank(); v.id_valid = 1; v.rs = 1; v.rt = 2; v.rd = 3; v.d1 = 5; v.d2 = 7; v.rw = 1;
    v.e_valid = 1; v.e_rw = 1; v.e_rd = 3; v.e_d1 = 5; v.e_d2 = 7; v.e_sd = 7; tbl.push_back(v);
    // 3: SUB r8 = r4 - r0
    v = blank(); v.id_valid = 1; v.op = 1; v.rs = 4; v.rd = 8; v.d1 = 32'h11; v.d2 = 32'h22; v.rw = 1;
    v.e_valid = 1; v.e_op = 1; v.e_rw = 1; v.e_rd = 8; v.e_d1 = 32'h11; v.e_d2 = 32'h22; v.e_sd = 32'h22;
    tbl.push_back(v);
    // 4: stalled, MEM and WB both write r4: MEM wins
    v = blank(); v.stall = 1; v.m_rw = 1; v.m_rd = 4; v.m_res = 32'hAA; v.w_rw = 1; v.w_rd = 4; v.w_res = 32'hBB;
    v.e_valid = 1; v.e_op = 1; v.e_rw = 1; v.e_rd = 8; v.e_d2 = 32'h22; v.e_sd = 32'h22;
`ifdef ID_EX_FORWARD_EN
    v.e_d1 = 32'hAA;
`else
    v.e_d1 = 32'h11;
`endif
    tbl.push_back(v);
    // 5: rs = rt = r0 with writers targeting r0: no forwarding
    v = blank(); v.id_valid = 1; v.op = 2; v.rd = 9; v.d1 = 32'h44; v.d2 = 32'h55; v.rw = 1;
    v.m_rw = 1; v.m_res = 32'hAA; v.w_rw = 1; v.w_res = 32'hBB;
    v.e_valid = 1; v.e_op = 2; v.e_rw = 1; v.e_rd = 9; v.e_d1 = 32'h44; v.e_d2 = 32'h55; v.e_sd = 32'h55;
    tbl.push_back(v);
    // 6: LW r5, 0x10(r1)
    v = blank(); v.id_valid = 1; v.rs = 1; v.rd = 5; v.d1 = 32'h100; v.imm = 32'h10; v.alu_src = 1; v.rw = 1; v.mr = 1;
    v.e_valid = 1; v.e_rw = 1; v.e_mr = 1; v.e_rd = 5; v.e_d1 = 32'h100; v.e_d2 = 32'h10; v.e_sd = 0;
    tbl.push_back(v);
    // 7: ADD r10 = r5 + r2 right behind the load: bubble
    v = blank(); v.id_valid = 1; v.rs = 5; v.rt = 2; v.rd = 10; v.d1 = 3; v.d2 = 7; v.rw = 1;
    v.e_lus = 1; v.chk_data = 0; tbl.push_back(v);
    // 8: same instruction re-presented
    v.e_lus = 0; v.chk_data = 1; v.d1 = 32'h50;
    v.e_valid = 1; v.e_rw = 1; v.e_rd = 10; v.e_d1 = 32'h50; v.e_d2 = 7; v.e_sd = 7; tbl.push_back(v);
    // 9: rt = r6 (data 1), rd = r7
    v = blank(); v.id_valid = 1; v.rs = 1; v.rt = 6; v.rd = 7; v.d1 = 32'h20; v.d2 = 1; v.rw = 1;
    v.e_valid = 1; v.e_rw = 1; v.e_rd = 7; v.e_d1 = 32'h20; v.e_d2 = 1; v.e_sd = 1; tbl.push_back(v);
    // 10-12: three stall cycles, WB retires r6 = 9 in the middle one
    v = blank(); v.stall = 1;
    v.e_valid = 1; v.e_rw = 1; v.e_rd = 7; v.e_d1 = 32'h20; v.e_d2 = 1; v.e_sd = 1; tbl.push_back(v);
    v.w_rw = 1; v.w_rd = 6; v.w_res = 9;
`ifdef ID_EX_FORWARD_EN
    v.e_d2 = 9; v.e_sd = 9;
`endif
    tbl.push_back(v);
    v.w_rw = 0; v.w_rd = 0; v.w_res = 0; tbl.push_back(v);
    // 13: flush together with stall and a valid instruction
    v = blank(); v.flush = 1; v.stall = 1; v.id_valid = 1; v.op = 3; v.rs = 2; v.rt = 3; v.rd = 11; v.rw = 1; v.mw = 1;
    v.chk_data = 0; tbl.push_back(v);
    // 14: immediate path, rt = r12
    v = blank(); v.id_valid = 1; v.rt = 12; v.rd = 13; v.d2 = 1; v.imm = 32'hFFFF_FFF0; v.alu_src = 1; v.rw = 1;
    v.e_valid = 1; v.e_rw = 1; v.e_rd = 13; v.e_d2 = 32'hFFFF_FFF0; v.e_sd = 1; tbl.push_back(v);
    // 15: stalled, MEM writes r12 = 0x33
    v = blank(); v.stall = 1; v.m_rw = 1; v.m_rd = 12; v.m_res = 32'h33;
    v.e_valid = 1; v.e_rw = 1; v.e_rd = 13; v.e_d2 = 32'hFFFF_FFF0;
`ifdef ID_EX_FORWARD_EN
    v.e_sd = 32'h33;
`else
    v.e_sd = 1;
`endif
    tbl.push_back(v);
    // 16: reads r12 while MEM is still writing it
    v = blank(); v.id_valid = 1; v.rs = 12; v.rd = 14; v.d1 = 5; v.d2 = 6; v.rw = 1;
    v.m_rw = 1; v.m_rd = 12; v.m_res = 32'h33;
`ifdef ID_EX_FORWARD_EN
    v.e_valid = 1; v.e_rw = 1; v.e_rd = 14; v.e_d1 = 32'h33; v.e_d2 = 6; v.e_sd = 6;
`else
    v.e_lus = 1; v.chk_data = 0;
`endif
    tbl.push_back(v);
    // 17: reset while stalled with a valid instruction
    v = blank(); v.reset = 1; v.stall = 1; v.id_valid = 1; v.rs = 1; v.rd = 2; v.rw = 1; v.d1 = 7;
    tbl.push_back(v);
    // 18: load into r0
    v = blank(); v.id_valid = 1; v.imm = 4; v.alu_src = 1; v.rw = 1; v.mr = 1;
    v.e_valid = 1; v.e_rw = 1; v.e_mr = 1; v.e_d2 = 4; tbl.push_back(v);
    // 19: reads r0 behind it: never a hazard
    v = blank(); v.id_valid = 1; v.rd = 15; v.d1 = 9; v.d2 = 32'hA; v.rw = 1;
    v.e_valid = 1; v.e_rw = 1; v.e_rd = 15; v.e_d1 = 9; v.e_d2 = 32'hA; v.e_sd = 32'hA; tbl.push_back(v);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      if (tbl[i].chk_lus) check("load_use_stall", i, 32'(bus.load_use_stall), 32'(tbl[i].e_lus));
      @(posedge clk);
      #1;
      check("ex_valid", i, 32'(bus.ex_valid), 32'(tbl[i].e_valid));
      check("ex_reg_write", i, 32'(bus.ex_reg_write), 32'(tbl[i].e_rw));
      check("ex_mem_read", i, 32'(bus.ex_mem_read), 32'(tbl[i].e_mr));
      check("ex_mem_write", i, 32'(bus.ex_mem_write), 32'(tbl[i].e_mw));
      if (tbl[i].chk_data) begin
        check("ex_alu_op", i, 32'(bus.ex_alu_op), 32'(tbl[i].e_op));
        check("ex_rd", i, 32'(bus.ex_rd), 32'(tbl[i].e_rd));
        check("ex_data1", i, bus.ex_data1, tbl[i].e_d1);
        check("ex_data2", i, bus.ex_data2, tbl[i].e_d2);
        check("ex_store_data", i, bus.ex_store_data, tbl[i].e_sd);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
